// File: rtl/mpu_mem_store_sink.sv
// rtl/mpu_mem_store_sink.sv - memory-side sink for the mpu_store matrix stream
// Accepts row-major elements into an FP-word memory at base + i*n + j, with a registered read port.
module mpu_mem_store_sink #(
  parameter int FP        = 32,
  parameter int MAX_DIM   = 8,
  parameter int DIM_W     = 4,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_in,
  input  logic [ADDR_W-1:0]    base_addr_in,
  output logic [ADDR_W-1:0]    mem_store_addr_out,
  input  logic                 mem_store_en_in,
  input  logic [DIM_W-1:0]     mem_m_store_size_in,
  input  logic [DIM_W-1:0]     mem_n_store_size_in,
  input  logic [FP-1:0]        mem_store_element_in,
  input  logic [ADDR_W-1:0]    rd_addr_in,
  output logic [FP-1:0]        rd_data_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 error_out,
  output logic                 stray_out,
  output logic [2*DIM_W-1:0]   elem_count_out
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RECV, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_base;
  logic [DIM_W-1:0]    r_m;
  logic [DIM_W-1:0]    r_n;
  logic [DIM_W-1:0]    r_i;
  logic [DIM_W-1:0]    r_j;
  logic [2*DIM_W-1:0]  r_count;
  logic                r_error;
  logic [FP-1:0]       r_rd_data;
  logic [FP-1:0]       r_mem [MEM_DEPTH];

  logic                w_size_ok;
  logic                w_single;
  logic                w_last;
  logic                w_accept_start;
  logic                w_wr_en;
  logic [2*DIM_W-1:0]  w_offset;
  logic [ADDR_W-1:0]   w_wr_addr;

  // Size legality is judged on the live inputs because it only matters on the first beat.
  assign w_size_ok = (mem_m_store_size_in != '0) && (mem_n_store_size_in != '0) &&
                     (mem_m_store_size_in <= DIM_W'(MAX_DIM)) &&
                     (mem_n_store_size_in <= DIM_W'(MAX_DIM));
  assign w_single  = (mem_m_store_size_in == DIM_W'(1)) && (mem_n_store_size_in == DIM_W'(1));
  assign w_last    = (r_i == r_m - DIM_W'(1)) && (r_j == r_n - DIM_W'(1));

  assign w_offset  = {{DIM_W{1'b0}}, r_i} * {{DIM_W{1'b0}}, r_n} + {{DIM_W{1'b0}}, r_j};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_in) w_next = S_ARMED;
      end
      S_ARMED: begin
        if (mem_store_en_in) begin
          if (!w_size_ok)    w_next = S_IDLE;
          else if (w_single) w_next = S_DONE;
          else               w_next = S_RECV;
        end
      end
      S_RECV: begin
        if (mem_store_en_in && w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = start_in ? S_ARMED : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_out       = 1'b0;
    done_out       = 1'b0;
    stray_out      = 1'b0;
    w_accept_start = 1'b0;
    w_wr_en        = 1'b0;
    w_wr_addr      = r_base;
    case (r_state)
      S_IDLE: begin
        stray_out      = mem_store_en_in;
        w_accept_start = start_in;
      end
      S_ARMED: begin
        busy_out = 1'b1;
        w_wr_en  = mem_store_en_in && w_size_ok;
      end
      S_RECV: begin
        busy_out  = 1'b1;
        w_wr_en   = mem_store_en_in;
        w_wr_addr = r_base + ADDR_W'(w_offset);
      end
      S_DONE: begin
        done_out       = 1'b1;
        stray_out      = mem_store_en_in;
        w_accept_start = start_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base  <= '0;
      r_m     <= '0;
      r_n     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      r_error <= 1'b0;
      if (w_accept_start) begin
        r_base  <= base_addr_in;
        r_count <= '0;
      end
      if (r_state == S_ARMED && mem_store_en_in) begin
        if (w_size_ok) begin
          r_m     <= mem_m_store_size_in;
          r_n     <= mem_n_store_size_in;
          r_count <= {{(2*DIM_W-1){1'b0}}, 1'b1};
          // A single-column matrix moves straight to the next row.
          if (mem_n_store_size_in == DIM_W'(1)) begin
            r_i <= DIM_W'(1);
            r_j <= '0;
          end else begin
            r_i <= '0;
            r_j <= DIM_W'(1);
          end
        end else begin
          r_error <= 1'b1;
        end
      end
      if (r_state == S_RECV && mem_store_en_in) begin
        r_count <= r_count + 1'b1;
        if (r_j == r_n - DIM_W'(1)) begin
          r_j <= '0;
          r_i <= r_i + DIM_W'(1);
        end else begin
          r_j <= r_j + DIM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= mem_store_element_in;
  end

  // Registered read samples the pre-write contents, so same-address read/write returns old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr_in];
    end
  end

  assign mem_store_addr_out = r_base;
  assign rd_data_out        = r_rd_data;
  assign error_out          = r_error;
  assign elem_count_out     = r_count;

endmodule
